tt_eqv_sweeper: RTL and testbench
=================================

# tt_eqv_sweeper

Parametrised exhaustive equivalence checker for small Boolean gate netlists. It holds a golden N-input truth table and sweeps all 2^N input vectors through up to NCH external device-under-test netlists, each registered DUT_LAT cycles deep. Per channel it reports the observed truth-table signature, the mismatch count and the first failing vector. It sits beside the synthesized gate netlists as their on-chip or simulation-side equivalence harness.

## Interface
- N_IN, default 4: number of DUT inputs; TT_W = 2^N_IN is a derived localparam.
- NCH, default 1: number of DUT channels checked in parallel.
- DUT_LAT, default 0: DUT pipeline latency in cycles. 0 means combinational.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_load  in  1  load golden table from cfg_tt
- cfg_tt  in  TT_W  golden truth table
- start  in  1  begin sweep
- abort  in  1  cancel sweep
- sweep_vec  out  N_IN  vector driven to all DUTs; input 0 is the MSB
- sweep_valid  out  1  sweep_vec is a live sweep vector
- dut_bit  in  NCH  DUT outputs, one per channel
- busy  out  1  sweep in progress
- done  out  1  results valid
- pass  out  1  all channels matched
- chan_pass  out  NCH  per-channel match
- sig  out  NCH*TT_W  observed table per channel
- mm_cnt  out  NCH*(N_IN+1)  mismatches per channel
- first_fail  out  NCH*N_IN  lowest failing vector per channel; 0 if none

## Operation
- Table encoding: for vector value k, with input 0 as the MSB of k, the output is bit (TT_W-1-k) of the table. Example with 16'hFC79: k=0 gives 1, k=6 gives 0, k=8 gives 0.
- States: IDLE, RUN, DRAIN, DONE.
- cfg_load is accepted only in IDLE or DONE and is ignored in RUN and DRAIN. If cfg_load and start are both asserted, the load takes effect first.
- start, accepted in IDLE or DONE:
  - clears sig, mm_cnt, first_fail and done
  - sets k=0 and moves to RUN
  - is ignored in RUN and DRAIN
- RUN:
  - drives sweep_vec=k with sweep_valid=1, and k increments every cycle
  - after k=TT_W-1 is issued, goes to DRAIN, or directly to DONE when DUT_LAT=0
- Sampling:
  - dut_bit for vector k is sampled DUT_LAT cycles after sweep_vec=k is presented
  - the expected bit and k travel through a DUT_LAT-deep shift pipeline
- Per sampled vector and channel:
  - sig bit (TT_W-1-k) is set to the sampled bit
  - on mismatch, mm_cnt is incremented; if it is the first mismatch, first_fail is set to k
  - mm_cnt cannot overflow, because its width is N_IN+1
- DRAIN: waits DUT_LAT cycles, then moves to DONE.
- DONE: done=1 and pass/chan_pass are valid. They hold until the next start, abort or reset.
- abort, in any state: returns to IDLE with busy=0 and done=0. Result registers are not cleared.
- Reset value of every output is 0, and the golden table resets to 0.

## Timing
- start sampled at edge 0. sweep_vec=0 is valid from edge 1, and vector k is valid in cycle k+1.
- busy is high from edge 1 until done rises.
- done and pass rise at edge TT_W+DUT_LAT+1. With defaults that is edge 17, for a total of 17 cycles.
- sweep_valid is low outside RUN; sweep_vec holds its last value.
- Asynchronous reset mid-sweep forces IDLE and all outputs to 0 immediately. The first sweep after reset restarts from k=0.

## Structure
- Package tt_eqv_pkg contains:
  - the state enum
  - the tt_bit(table, k) function implementing the bit-order mapping
  - the derived width helper
- Sub-module tt_eqv_chan is instantiated NCH times. Each instance holds one channel's signature, mismatch counter and first-fail register. The top level holds the FSM, the vector counter and the shared expected-bit/index pipeline.

## Test plan
- N_IN=4, NCH=1, DUT_LAT=0, golden 16'hFC79, DUT models the 0xFC79 function:
  - expect sig=16'hFC79, mm_cnt=0, pass=1
  - expect done at edge 17
- Same setup, DUT with entry k=8 flipped to 1:
  - expect sig=16'hFCF9, mm_cnt=1, first_fail=8, pass=0
- DUT_LAT=2 with a two-stage registered correct DUT:
  - expect pass=1 and done at edge 19
  - expect no false mismatch from pipeline skew
- NCH=2, channel 0 correct and channel 1 tied to 0:
  - expect chan_pass=2'b01, channel 1 mm_cnt=11 and first_fail=0, pass=0
- abort asserted while sweep_vec=5, then cfg_load:
  - abort gives IDLE, busy=0, done=0
  - a cfg_load attempted during RUN is ignored (golden unchanged)
  - the next start re-sweeps from 0 and passes
- rst_n pulsed low mid-RUN:
  - all outputs go to 0 asynchronously and the golden table reads 0
  - a sweep after reload completes normally

Source files
------------

// File: rtl/tt_eqv_pkg.sv
// Shared types and helpers for the truth-table equivalence sweeper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package tt_eqv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int MAX_N_IN = 8;
    localparam int MAX_TT_W = 1 << MAX_N_IN;

    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

    // Input 0 is the MSB of k, so vector k lives at table bit (TT_W-1-k).
    function automatic logic tt_bit(input logic [MAX_TT_W-1:0] tbl,
                                    input logic [MAX_N_IN-1:0] k,
                                    input int                  n_in);
        logic [MAX_N_IN-1:0] idx;
        idx = MAX_N_IN'(tt_width(n_in) - 1 - int'(k));
        return tbl[idx];
    endfunction

endpackage

// File: rtl/tt_eqv_chan.sv
// One channel's result state: observed signature, mismatch count, first failing vector.
// Latency: results update on the edge a sample is presented.
// Backpressure: none; accepts one sample per cycle.
module tt_eqv_chan #(
    parameter int N_IN = 4,
    parameter int TT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            smp_vld,
    input  logic [N_IN-1:0] smp_k,
    input  logic            smp_exp,
    input  logic            dut_bit,
    output logic [TT_W-1:0] sig,
    output logic [N_IN:0]   mm_cnt,
    output logic [N_IN-1:0] first_fail
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig        <= '0;
            mm_cnt     <= '0;
            first_fail <= '0;
        end else if (clr) begin
            sig        <= '0;
            mm_cnt     <= '0;
            first_fail <= '0;
        end else if (smp_vld) begin
            // ~k is TT_W-1-k for an N_IN-bit index.
            sig[~smp_k] <= dut_bit;
            if (dut_bit != smp_exp) begin
                mm_cnt <= mm_cnt + (N_IN+1)'(1);
                if (mm_cnt == '0)
                    first_fail <= smp_k;
            end
        end
    end

endmodule

// File: rtl/tt_eqv_sweeper.sv
// Exhaustive equivalence sweeper: drives all 2^N_IN vectors to NCH DUT netlists and checks them.
// Latency: done rises TT_W+DUT_LAT+1 cycles after start is sampled.
// Backpressure: none; one vector per cycle, start/cfg_load ignored while busy.
module tt_eqv_sweeper
    import tt_eqv_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int NCH     = 1,
    parameter int DUT_LAT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_load,
    input  logic [(1<<N_IN)-1:0]   cfg_tt,
    input  logic                   start,
    input  logic                   abort,
    output logic [N_IN-1:0]        sweep_vec,
    output logic                   sweep_valid,
    input  logic [NCH-1:0]         dut_bit,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [NCH-1:0]         chan_pass,
    output logic [NCH*(1<<N_IN)-1:0] sig,
    output logic [NCH*(N_IN+1)-1:0]  mm_cnt,
    output logic [NCH*N_IN-1:0]      first_fail
);

    localparam int TT_W = tt_width(N_IN);
    localparam int DW   = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;

    state_t          state, state_nxt;
    logic [TT_W-1:0] golden;
    logic [N_IN-1:0] k;
    logic [DW-1:0]   drn_cnt;
    logic            clr;
    logic            k_last;
    logic            drn_last;
    logic            idle_or_done;
    logic            run_exp;
    logic            smp_vld;
    logic            smp_en;
    logic [N_IN-1:0] smp_k;
    logic            smp_exp;

    assign k_last       = &k;
    assign drn_last     = (drn_cnt == DW'(DUT_LAT - 1));
    assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
    assign run_exp      = tt_bit(MAX_TT_W'(golden), MAX_N_IN'(k), N_IN);

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    clr       = 1'b1;
                end
            end
            ST_RUN: begin
                if (k_last)
                    state_nxt = (DUT_LAT == 0) ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drn_last)
                    state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Abort overrides everything and leaves results untouched.
        if (abort) begin
            state_nxt = ST_IDLE;
            clr       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            golden  <= '0;
            k       <= '0;
            drn_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (cfg_load && idle_or_done)
                golden <= cfg_tt;
            if (clr)
                k <= '0;
            else if (state == ST_RUN && !k_last)
                k <= k + N_IN'(1);
            if (state == ST_DRAIN)
                drn_cnt <= drn_cnt + DW'(1);
            else
                drn_cnt <= '0;
        end
    end

    // Expected bit and index ride alongside the DUT pipeline so samples line up.
    generate
        if (DUT_LAT == 0) begin : g_comb
            assign smp_vld = (state == ST_RUN);
            assign smp_k   = k;
            assign smp_exp = run_exp;
        end else begin : g_pipe
            logic            pipe_vld [DUT_LAT];
            logic [N_IN-1:0] pipe_k   [DUT_LAT];
            logic            pipe_exp [DUT_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DUT_LAT; i++) begin
                        pipe_vld[i] <= 1'b0;
                        pipe_k[i]   <= '0;
                        pipe_exp[i] <= 1'b0;
                    end
                end else begin
                    pipe_vld[0] <= (state == ST_RUN) && !abort && !clr;
                    pipe_k[0]   <= k;
                    pipe_exp[0] <= run_exp;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        pipe_vld[i] <= pipe_vld[i-1] && !abort && !clr;
                        pipe_k[i]   <= pipe_k[i-1];
                        pipe_exp[i] <= pipe_exp[i-1];
                    end
                end
            end

            assign smp_vld = pipe_vld[DUT_LAT-1];
            assign smp_k   = pipe_k[DUT_LAT-1];
            assign smp_exp = pipe_exp[DUT_LAT-1];
        end
    endgenerate

    assign smp_en = smp_vld && !abort && ((state == ST_RUN) || (state == ST_DRAIN));

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_chan
            tt_eqv_chan #(
                .N_IN (N_IN),
                .TT_W (TT_W)
            ) u_chan (
                .clk        (clk),
                .rst_n      (rst_n),
                .clr        (clr),
                .smp_vld    (smp_en),
                .smp_k      (smp_k),
                .smp_exp    (smp_exp),
                .dut_bit    (dut_bit[c]),
                .sig        (sig[c*TT_W +: TT_W]),
                .mm_cnt     (mm_cnt[c*(N_IN+1) +: (N_IN+1)]),
                .first_fail (first_fail[c*N_IN +: N_IN])
            );
            assign chan_pass[c] = done && (mm_cnt[c*(N_IN+1) +: (N_IN+1)] == '0);
        end
    endgenerate

    assign sweep_vec   = k;
    assign sweep_valid = (state == ST_RUN);
    assign busy        = (state == ST_RUN) || (state == ST_DRAIN);
    assign done        = (state == ST_DONE);
    assign pass        = done && (&chan_pass);

endmodule

// File: tb/tb_tt_eqv_sweeper.sv
// Bench for tt_eqv_sweeper: two instances (DUT_LAT=0 and DUT_LAT=2, two channels each)
// checked cycle by cycle against a truth-table model plus literal expectations.
module tb_tt_eqv_sweeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_load_s [2];
    logic [15:0] cfg_tt_s   [2];
    logic        start_s    [2];
    logic        abort_s    [2];
    logic [3:0]  vec_s      [2];
    logic        vld_s      [2];
    logic [1:0]  dut_s      [2];
    logic        busy_s     [2];
    logic        done_s     [2];
    logic        pass_s     [2];
    logic [1:0]  cp_s       [2];
    logic [31:0] sig_s      [2];
    logic [9:0]  mm_s       [2];
    logic [7:0]  ff_s       [2];
    logic [1:0]  pb1, pb2;
    int          mode0 = 0;
    int          mode1 = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    tt_eqv_sweeper #(.N_IN(4), .NCH(2), .DUT_LAT(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load_s[0]), .cfg_tt(cfg_tt_s[0]),
        .start(start_s[0]), .abort(abort_s[0]), .sweep_vec(vec_s[0]), .sweep_valid(vld_s[0]),
        .dut_bit(dut_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .chan_pass(cp_s[0]), .sig(sig_s[0]), .mm_cnt(mm_s[0]), .first_fail(ff_s[0])
    );

    tt_eqv_sweeper #(.N_IN(4), .NCH(2), .DUT_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load_s[1]), .cfg_tt(cfg_tt_s[1]),
        .start(start_s[1]), .abort(abort_s[1]), .sweep_vec(vec_s[1]), .sweep_valid(vld_s[1]),
        .dut_bit(dut_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .chan_pass(cp_s[1]), .sig(sig_s[1]), .mm_cnt(mm_s[1]), .first_fail(ff_s[1])
    );

    // Golden function output for vector k: input 0 is the MSB of k.
    function automatic logic ref_bit(input logic [15:0] t, input int k);
        logic [15:0] s;
        s = t >> (15 - k);
        return s[0];
    endfunction

    // DUT netlist behaviours: 0 = 0xFC79 function, 1 = same with k=8 flipped to 1, 2 = tied 0.
    function automatic logic dfn(input int mode, input logic [3:0] v);
        int k;
        k = int'(v);
        case (mode)
            0: return ref_bit(16'hFC79, k);
            1: return (k == 8) ? 1'b1 : ref_bit(16'hFC79, k);
            default: return 1'b0;
        endcase
    endfunction

    assign dut_s[0] = {dfn(mode1, vec_s[0]), dfn(mode0, vec_s[0])};

    always @(posedge clk) begin
        pb1 <= {dfn(mode1, vec_s[1]), dfn(mode0, vec_s[1])};
        pb2 <= pb1;
    end
    assign dut_s[1] = pb2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model(input logic [15:0] gold, input int mode,
                         output logic [15:0] s, output logic [4:0] mm, output logic [3:0] ff);
        logic b;
        s = '0; mm = '0; ff = '0;
        for (int k = 0; k < 16; k++) begin
            b = dfn(mode, 4'(k));
            s = s | (16'(b) << (15 - k));
            if (b != ref_bit(gold, k)) begin
                if (mm == 0) ff = 4'(k);
                mm = mm + 5'd1;
            end
        end
    endtask

    task automatic chk_zero(input int inst);
        chk("rst_vec", 32'(vec_s[inst]), 0);
        chk("rst_valid", 32'(vld_s[inst]), 0);
        chk("rst_busy", 32'(busy_s[inst]), 0);
        chk("rst_done", 32'(done_s[inst]), 0);
        chk("rst_pass", 32'(pass_s[inst]), 0);
        chk("rst_chan_pass", 32'(cp_s[inst]), 0);
        chk("rst_sig", sig_s[inst], 0);
        chk("rst_mm", 32'(mm_s[inst]), 0);
        chk("rst_ff", 32'(ff_s[inst]), 0);
    endtask

    // One full sweep; gold is the table the DUT is expected to hold.
    task automatic run(input int inst, input bit load, input logic [15:0] gold,
                       input int m0, input int m1, input int lat, input int exp_edge);
        int done_at;
        logic [15:0] s;
        logic [4:0]  mm;
        logic [3:0]  ff;
        logic [1:0]  cp;
        mode0 = m0;
        mode1 = m1;
        cfg_tt_s[inst]   = gold;
        cfg_load_s[inst] = load;
        start_s[inst]    = 1'b1;
        @(posedge clk); #1;
        cfg_load_s[inst] = 1'b0;
        start_s[inst]    = 1'b0;
        done_at = -1;
        for (int c = 1; c <= 20 + lat; c++) begin
            chk("cyc_valid", 32'(vld_s[inst]), 32'(c <= 16));
            if (c <= 16) chk("cyc_vec", 32'(vec_s[inst]), 32'(c - 1));
            chk("cyc_busy", 32'(busy_s[inst]), 32'(c < 17 + lat));
            chk("cyc_done", 32'(done_s[inst]), 32'(c >= 17 + lat));
            if (done_s[inst] === 1'b1) begin
                done_at = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk("done_edge", 32'(done_at), 32'(exp_edge));
        cp = '0;
        for (int ch = 0; ch < 2; ch++) begin
            model(gold, (ch == 0) ? m0 : m1, s, mm, ff);
            chk("sig", 32'(sig_s[inst][ch*16 +: 16]), 32'(s));
            chk("mm_cnt", 32'(mm_s[inst][ch*5 +: 5]), 32'(mm));
            chk("first_fail", 32'(ff_s[inst][ch*4 +: 4]), 32'(ff));
            cp[ch] = (mm == 0);
        end
        chk("chan_pass", 32'(cp_s[inst]), 32'(cp));
        chk("pass", 32'(pass_s[inst]), 32'(&cp));
        @(posedge clk); #1;
        chk("done_hold", 32'(done_s[inst]), 1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            cfg_load_s[i] = 1'b0; cfg_tt_s[i] = '0; start_s[i] = 1'b0; abort_s[i] = 1'b0;
        end
        #22;
        chk_zero(0);
        chk_zero(1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Correct DUT, combinational.
        run(0, 1'b1, 16'hFC79, 0, 0, 0, 17);
        chk("lit_sig_ok", 32'(sig_s[0][15:0]), 32'h0000FC79);
        chk("lit_mm_ok", 32'(mm_s[0][4:0]), 0);
        chk("lit_pass_ok", 32'(pass_s[0]), 1);

        // Entry k=8 flipped.
        run(0, 1'b1, 16'hFC79, 1, 0, 0, 17);
        chk("lit_sig_flip", 32'(sig_s[0][15:0]), 32'h0000FCF9);
        chk("lit_mm_flip", 32'(mm_s[0][4:0]), 1);
        chk("lit_ff_flip", 32'(ff_s[0][3:0]), 8);
        chk("lit_pass_flip", 32'(pass_s[0]), 0);

        // Two-stage registered DUT.
        run(1, 1'b1, 16'hFC79, 0, 0, 2, 19);
        chk("lit_pass_lat2", 32'(pass_s[1]), 1);
        chk("lit_mm_lat2", 32'(mm_s[1]), 0);

        // Channel 1 tied low.
        run(0, 1'b1, 16'hFC79, 0, 2, 0, 17);
        chk("lit_cp_tie", 32'(cp_s[0]), 32'h1);
        chk("lit_mm1_tie", 32'(mm_s[0][9:5]), 11);
        chk("lit_ff1_tie", 32'(ff_s[0][7:4]), 0);
        chk("lit_pass_tie", 32'(pass_s[0]), 0);

        // Abort at vector 5 with a load attempted mid-run.
        mode0 = 0; mode1 = 0;
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        cfg_tt_s[0] = 16'h0000;
        cfg_load_s[0] = 1'b1;
        @(posedge clk); #1;
        cfg_load_s[0] = 1'b0;
        n = 0;
        while (!(vld_s[0] === 1'b1 && vec_s[0] === 4'd5) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reach_vec5", 32'(vec_s[0]), 5);
        abort_s[0] = 1'b1;
        @(posedge clk); #1;
        abort_s[0] = 1'b0;
        chk("abort_busy", 32'(busy_s[0]), 0);
        chk("abort_done", 32'(done_s[0]), 0);
        chk("abort_valid", 32'(vld_s[0]), 0);
        run(0, 1'b0, 16'hFC79, 0, 0, 0, 17);
        chk("lit_pass_after_abort", 32'(pass_s[0]), 1);

        // Asynchronous reset mid-run on both instances.
        start_s[0] = 1'b1;
        start_s[1] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero(0);
        chk_zero(1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        // Golden must now be zero: a tied-low channel matches, a 0xFC79 channel does not.
        run(0, 1'b0, 16'h0000, 2, 0, 0, 17);
        chk("lit_cp_zero_gold", 32'(cp_s[0]), 32'h1);
        run(0, 1'b1, 16'hFC79, 0, 0, 0, 17);
        chk("lit_pass_reload", 32'(pass_s[0]), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
